// File: rtl/exp_conv_pkg.sv
// rtl/exp_conv_pkg.sv - shared types and defaults for the expand convolution kernel path
package exp_conv_pkg;

  localparam int ADDR_W_DEF       = 7;
  localparam int CNT_W_DEF        = 16;
  localparam int DRAIN_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - wrapping counter with clear, enable and programmable terminal value
module mod_n_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             term_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign term_o  = (count_q == term_val_i);
  assign count_o = count_q;

  // Clear wins over enable so a restart never sees a stale increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = term_o ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/exp_kernel_scheduler.sv
// rtl/exp_kernel_scheduler.sv - kernel RAM read sequencing for one expand layer
module exp_kernel_scheduler
  import exp_conv_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] one_exp_ker_addr_limit_i,
  input  logic [CNT_W-1:0]  layer_word_count_i,
  input  logic              ker_load_done_i,
  input  logic              kerl_req_i,
  output logic              kerl_ready_o,
  output logic [ADDR_W-1:0] ker_rd_addr_o,
  output logic              ker_rd_en_o,
  output logic              word_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [CNT_W-1:0]  wc_q, wc_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic              err_q, err_d;
  logic              cnt_clr;
  logic              cfg_ok;
  logic              a_term;
  logic              w_term;
  logic [CNT_W-1:0]  w_count_unused;

  assign cfg_ok       = (one_exp_ker_addr_limit_i != '0) && (layer_word_count_i != '0);
  assign kerl_ready_o = (state_q == ST_RUN) && ker_load_done_i;
  assign ker_rd_en_o  = kerl_req_i && kerl_ready_o;
  assign word_last_o  = ker_rd_en_o && a_term;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;

  mod_n_counter #(.WIDTH(ADDR_W)) u_addr_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (cnt_clr),
    .en_i       (ker_rd_en_o),
    .term_val_i (n_q - ADDR_W'(1)),
    .count_o    (ker_rd_addr_o),
    .term_o     (a_term)
  );

  mod_n_counter #(.WIDTH(CNT_W)) u_word_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (cnt_clr),
    .en_i       (word_last_o),
    .term_val_i (wc_q - CNT_W'(1)),
    .count_o    (w_count_unused),
    .term_o     (w_term)
  );

  // A start in any state restarts the layer; an illegal one always lands in IDLE.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wc_d    = wc_q;
    drain_d = drain_q;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    if (start_i) begin
      if (cfg_ok) begin
        n_d     = one_exp_ker_addr_limit_i;
        wc_d    = layer_word_count_i;
        drain_d = '0;
        cnt_clr = 1'b1;
        state_d = ST_WAIT_LOAD;
      end else begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_WAIT_LOAD: if (ker_load_done_i) state_d = ST_RUN;
        ST_RUN:       if (word_last_o && w_term) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            state_d = ST_DONE;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
        ST_DONE:      state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      wc_q    <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wc_q    <= wc_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

endmodule
